// File: rtl/conway_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: FSM state type,
// default word width and counter sizing helper.
package conway_pkg;

    localparam int DEFAULT_DATA_SIZE = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } s2p_state_t;

    // Counter must reach data_size-1 without wrapping; one spare bit keeps it simple.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// MSB-first serial-to-parallel deserializer with frame sync, valid/ready output
// handshake and a sticky overrun flag for words dropped while the output is full.
module serial_to_parallel
    import conway_pkg::*;
#(
    parameter int data_size = DEFAULT_DATA_SIZE
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 DATA,
    input  logic                 SHIFT_EN,
    input  logic                 START,
    input  logic                 READY,
    output logic [data_size-1:0] DATA_OUT,
    output logic                 VALID,
    output logic                 BUSY,
    output logic                 OVERRUN
);

    localparam int             CW   = cnt_width(data_size);
    localparam int             SR_W = data_size - 1;
    localparam logic [CW-1:0]  LAST = CW'(data_size - 1);

    // Only data_size-1 bits need holding; the final bit goes straight into the word.
    s2p_state_t            state;
    logic [SR_W-1:0]       sr;
    logic [CW-1:0]         cnt;

    logic [data_size-1:0]  shifted;
    logic                  do_shift;
    logic                  complete;

    assign shifted  = {sr, DATA};
    assign do_shift = (state == RECV) && SHIFT_EN && !START;
    assign complete = do_shift && (cnt == LAST);
    assign BUSY     = (state == RECV);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (START) begin
            // Frame sync wins over everything; a coincident bit is the first of the new frame.
            state <= RECV;
            sr    <= SHIFT_EN ? SR_W'(DATA) : '0;
            cnt   <= SHIFT_EN ? CW'(1) : '0;
        end else if (do_shift) begin
            if (complete) begin
                state <= IDLE;
                sr    <= '0;
                cnt   <= '0;
            end else begin
                sr    <= shifted[SR_W-1:0];
                cnt   <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA_OUT <= '0;
            VALID    <= 1'b0;
            OVERRUN  <= 1'b0;
        end else if (complete) begin
            // A handshake on the completing edge frees the slot for the new word.
            if (!VALID || READY) begin
                DATA_OUT <= shifted;
                VALID    <= 1'b1;
            end else begin
                OVERRUN  <= 1'b1;
            end
        end else if (VALID && READY) begin
            VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel (data_size=8): stimulus pushes expected
// words, a negedge monitor pops and compares on every output handshake.
module tb_serial_to_parallel;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         DATA = 1'b0;
    logic         SHIFT_EN = 1'b0;
    logic         START = 1'b0;
    logic         READY = 1'b0;
    logic [W-1:0] DATA_OUT;
    logic         VALID;
    logic         BUSY;
    logic         OVERRUN;

    int           tests = 0;
    int           fails = 0;
    int           hs_count = 0;
    int           hs_base;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    serial_to_parallel #(.data_size(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DATA     (DATA),
        .SHIFT_EN (SHIFT_EN),
        .START    (START),
        .READY    (READY),
        .DATA_OUT (DATA_OUT),
        .VALID    (VALID),
        .BUSY     (BUSY),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        START    = st;
        SHIFT_EN = 1'b1;
        DATA     = b;
        tick();
        START    = 1'b0;
        SHIFT_EN = 1'b0;
        DATA     = 1'b0;
    endtask

    // Sends the top nbits of w MSB first, START on the first bit; optional 1-3 cycle gaps.
    task automatic send_frame(input logic [W-1:0] w, input bit gaps, input bit ready_last,
                              input int nbits);
        for (int i = W - 1; i >= W - nbits; i--) begin
            if (ready_last && i == 0) READY = 1'b1;
            send_bit(w[i], i == W - 1);
            if (gaps) repeat (((W - 1 - i) % 3) + 1) tick();
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && VALID && READY) begin
            hs_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_unexpected: got %02h, required no word", DATA_OUT);
            end else begin
                mon_exp = exp_q.pop_front();
                if (DATA_OUT !== mon_exp) begin
                    fails++;
                    $display("FAIL scoreboard_word: got %02h, required %02h", DATA_OUT, mon_exp);
                end
            end
        end
    end

    initial begin
        // Reset state
        #2 RST = 1'b1;
        #1;
        check("rst_data_out", DATA_OUT, 8'h00);
        check("rst_valid",    W'(VALID),   8'h00);
        check("rst_busy",     W'(BUSY),    8'h00);
        check("rst_overrun",  W'(OVERRUN), 8'h00);
        tick();
        RST = 1'b0;

        // SHIFT_EN without START in IDLE is ignored
        SHIFT_EN = 1'b1;
        DATA     = 1'b1;
        repeat (3) tick();
        SHIFT_EN = 1'b0;
        DATA     = 1'b0;
        check("idle_ignore_busy",  W'(BUSY),  8'h00);
        check("idle_ignore_valid", W'(VALID), 8'h00);

        // Scenario 1: back-to-back bits, READY=1
        READY = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 8);
        check("s1_data_out", DATA_OUT,  8'hA5);
        check("s1_valid",    W'(VALID), 8'h01);
        check("s1_busy",     W'(BUSY),  8'h00);
        tick();
        check("s1_valid_clr", W'(VALID), 8'h00);

        // Scenario 2: gaps between bits
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 7);
        check("s2_valid_early", W'(VALID), 8'h00);
        check("s2_busy_mid",    W'(BUSY),  8'h01);
        send_bit(1'b1, 1'b0);
        check("s2_data_out", DATA_OUT,  8'hA5);
        check("s2_valid",    W'(VALID), 8'h01);
        tick();

        // Scenario 3: READY=0, second frame overruns
        READY = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 8);
        check("s3_valid1",   W'(VALID),   8'h01);
        check("s3_overrun1", W'(OVERRUN), 8'h00);
        send_frame(8'h3C, 1'b0, 1'b0, 8);
        check("s3_data_held", DATA_OUT,    8'hA5);
        check("s3_valid2",    W'(VALID),   8'h01);
        check("s3_overrun2",  W'(OVERRUN), 8'h01);
        READY = 1'b1;
        tick();
        check("s3_valid_clr",     W'(VALID),   8'h00);
        check("s3_overrun_stick", W'(OVERRUN), 8'h01);
        repeat (2) tick();
        check("s3_overrun_stick2", W'(OVERRUN), 8'h01);
        #2 RST = 1'b1;
        #1;
        check("s3_overrun_rst", W'(OVERRUN), 8'h00);
        RST = 1'b0;
        tick();

        // Scenario 4: aborted frame then 0x3C
        hs_base = hs_count;
        send_frame(8'hE0, 1'b0, 1'b0, 3);
        check("s4_valid_abort", W'(VALID), 8'h00);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 8);
        check("s4_data_out", DATA_OUT,    8'h3C);
        check("s4_overrun",  W'(OVERRUN), 8'h00);
        repeat (2) tick();
        check("s4_single_valid", W'(hs_count - hs_base), 8'h01);

        // Scenario 5: handshake on the completing edge
        READY = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 8);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, 8);
        check("s5_data_out", DATA_OUT,    8'h3C);
        check("s5_valid",    W'(VALID),   8'h01);
        check("s5_overrun",  W'(OVERRUN), 8'h00);
        tick();
        check("s5_valid_clr", W'(VALID), 8'h00);

        // Scenario 6: async reset mid-frame with VALID=1
        READY = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 8);
        send_frame(8'h3C, 1'b0, 1'b0, 5);
        check("s6_busy_pre", W'(BUSY), 8'h01);
        #2 RST = 1'b1;
        #1;
        check("s6_rst_data_out", DATA_OUT,    8'h00);
        check("s6_rst_valid",    W'(VALID),   8'h00);
        check("s6_rst_busy",     W'(BUSY),    8'h00);
        check("s6_rst_overrun",  W'(OVERRUN), 8'h00);
        RST = 1'b0;
        tick();
        READY = 1'b1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 8);
        check("s6_data_out", DATA_OUT,  8'h3C);
        check("s6_valid",    W'(VALID), 8'h01);
        repeat (3) tick();

        check("scoreboard_drained", W'(exp_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
